// File: rtl/pc_sequencer_if.sv
// Request/result bundle between the hazard, branch and decode logic and the next-PC sequencer.
// The master drives the requests and the current PC. The slave (the sequencer) drives the results.
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic [PC_W-1:0] pc_cur;
  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jmp;
  logic [PC_W-1:0] jmp_target;
  logic            halt_req;
  logic            resume;
  logic            exc;
  logic [PC_W-1:0] pc_next;
  logic            flush;
  logic            halted;
  logic [PC_W-1:0] epc;
  logic [7:0]      redirect_cnt;
  logic [1:0]      state;

  modport master (
    output pc_cur, stall, br_taken, br_target, jmp, jmp_target, halt_req, resume, exc,
    input  pc_next, flush, halted, epc, redirect_cnt, state
  );

  modport slave (
    input  pc_cur, stall, br_taken, br_target, jmp, jmp_target, halt_req, resume, exc,
    output pc_next, flush, halted, epc, redirect_cnt, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller for the 8-bit PC register. It selects pc_next from redirect, stall, halt and
// exception requests, and it owns the flush, halt state, exception PC capture and redirect counter.
module pc_sequencer #(
  parameter int unsigned     PC_W      = 8,
  parameter logic [PC_W-1:0] INC       = 8'd2,
  parameter logic [PC_W-1:0] RESET_VEC = 8'h00,
  parameter logic [PC_W-1:0] EXC_VEC   = 8'hF0
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e          state_r;
  state_e          next_state_s;
  logic [PC_W-1:0] epc_r;
  logic [7:0]      redirect_cnt_r;
  logic [PC_W-1:0] pc_next_s;
  logic [PC_W-1:0] pc_inc_s;
  logic            flush_s;
  logic            epc_load_s;
  logic            cnt_bump_s;

  // Sequential increment wraps modulo 2^PC_W.
  assign pc_inc_s = bus.pc_cur + INC;

  // Next-state, next-PC and side-effect decode.
  always_comb begin
    next_state_s = state_r;
    pc_next_s    = RESET_VEC;
    flush_s      = 1'b0;
    epc_load_s   = 1'b0;
    cnt_bump_s   = 1'b0;
    if (rst) begin
      next_state_s = ST_BOOT;
      pc_next_s    = RESET_VEC;
      flush_s      = 1'b1;
    end else begin
      case (state_r)
        ST_BOOT: begin
          pc_next_s    = RESET_VEC;
          flush_s      = 1'b1;
          next_state_s = ST_RUN;
        end
        ST_RUN: begin
          if (bus.exc) begin
            pc_next_s    = EXC_VEC;
            flush_s      = 1'b1;
            epc_load_s   = 1'b1;
            cnt_bump_s   = 1'b1;
            next_state_s = ST_FLUSH;
          end else if (bus.br_taken) begin
            pc_next_s    = bus.br_target;
            flush_s      = 1'b1;
            cnt_bump_s   = 1'b1;
            next_state_s = ST_FLUSH;
          end else if (bus.jmp) begin
            pc_next_s    = bus.jmp_target;
            flush_s      = 1'b1;
            cnt_bump_s   = 1'b1;
            next_state_s = ST_FLUSH;
          end else if (bus.stall) begin
            // A stalled halt instruction is not yet valid, so stall wins.
            pc_next_s = bus.pc_cur;
          end else if (bus.halt_req) begin
            pc_next_s    = bus.pc_cur;
            next_state_s = ST_HALT;
          end else begin
            pc_next_s = pc_inc_s;
          end
        end
        ST_FLUSH: begin
          flush_s = 1'b1;
          if (bus.exc) begin
            pc_next_s  = EXC_VEC;
            epc_load_s = 1'b1;
            cnt_bump_s = 1'b1;
          end else begin
            pc_next_s    = pc_inc_s;
            next_state_s = ST_RUN;
          end
        end
        ST_HALT: begin
          if (bus.exc) begin
            pc_next_s    = EXC_VEC;
            flush_s      = 1'b1;
            epc_load_s   = 1'b1;
            cnt_bump_s   = 1'b1;
            next_state_s = ST_FLUSH;
          end else if (bus.resume) begin
            pc_next_s    = bus.pc_cur;
            next_state_s = ST_RUN;
          end else begin
            pc_next_s = bus.pc_cur;
          end
        end
        default: begin
          pc_next_s    = RESET_VEC;
          flush_s      = 1'b1;
          next_state_s = ST_BOOT;
        end
      endcase
    end
  end

  // State, exception PC and saturating redirect counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_BOOT;
      epc_r          <= '0;
      redirect_cnt_r <= 8'd0;
    end else begin
      state_r <= next_state_s;
      if (epc_load_s) begin
        epc_r <= bus.pc_cur;
      end else begin
        epc_r <= epc_r;
      end
      if (cnt_bump_s && (redirect_cnt_r != 8'hFF)) begin
        redirect_cnt_r <= redirect_cnt_r + 8'd1;
      end else begin
        redirect_cnt_r <= redirect_cnt_r;
      end
    end
  end

  assign bus.pc_next      = pc_next_s;
  assign bus.flush        = flush_s;
  assign bus.halted       = (state_r == ST_HALT) && !rst;
  assign bus.epc          = epc_r;
  assign bus.redirect_cnt = redirect_cnt_r;
  assign bus.state        = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Closed-loop bench for pc_sequencer. The bench models the PC register, and a rule-level reference
// model checks every cycle. Directed scenarios run first, then randomized traffic.
module tb_pc_sequencer;

  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;
  localparam int M_HALT  = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   m_mode;
  logic [7:0] m_epc;
  int   m_cnt;
  int   cnt0;

  pc_sequencer_if #(.PC_W(8)) bus ();

  pc_sequencer #(
    .PC_W(8), .INC(8'd2), .RESET_VEC(8'h00), .EXC_VEC(8'hF0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_req();
    bus.stall    = 1'b0;
    bus.br_taken = 1'b0;
    bus.jmp      = 1'b0;
    bus.halt_req = 1'b0;
    bus.resume   = 1'b0;
    bus.exc      = 1'b0;
  endtask

  // Entry: posedge+1 with inputs driven. Exit: next posedge+1 with requests cleared.
  task automatic tick();
    logic [7:0] e_next;
    logic       e_flush;
    int         e_mode;
    logic       ld;
    logic       bump;
    logic [7:0] got_next;
    #3;
    e_mode  = m_mode;
    e_flush = 1'b0;
    ld      = 1'b0;
    bump    = 1'b0;
    e_next  = bus.pc_cur;
    if (rst) begin
      e_next = 8'h00; e_flush = 1'b1; e_mode = M_BOOT;
    end else if (m_mode == M_BOOT) begin
      e_next = 8'h00; e_flush = 1'b1; e_mode = M_RUN;
    end else if (bus.exc) begin
      e_next = 8'hF0; e_flush = 1'b1; ld = 1'b1; bump = 1'b1; e_mode = M_FLUSH;
    end else if (m_mode == M_FLUSH) begin
      e_next = bus.pc_cur + 8'd2; e_flush = 1'b1; e_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (bus.resume) e_mode = M_RUN;
    end else if (bus.br_taken) begin
      e_next = bus.br_target; e_flush = 1'b1; bump = 1'b1; e_mode = M_FLUSH;
    end else if (bus.jmp) begin
      e_next = bus.jmp_target; e_flush = 1'b1; bump = 1'b1; e_mode = M_FLUSH;
    end else if (bus.halt_req && !bus.stall) begin
      e_mode = M_HALT;
    end else if (!bus.stall) begin
      e_next = bus.pc_cur + 8'd2;
    end
    check_eq("pc_next", {24'd0, bus.pc_next}, {24'd0, e_next});
    check_eq("flush", {31'd0, bus.flush}, {31'd0, e_flush});
    check_eq("halted", {31'd0, bus.halted}, (m_mode == M_HALT && !rst) ? 32'd1 : 32'd0);
    check_eq("state", {30'd0, bus.state}, m_mode);
    check_eq("epc", {24'd0, bus.epc}, {24'd0, m_epc});
    check_eq("redirect_cnt", {24'd0, bus.redirect_cnt}, m_cnt);
    got_next = bus.pc_next;
    @(posedge clk);
    #1;
    if (rst) begin
      m_mode = M_BOOT; m_epc = 8'h00; m_cnt = 0;
    end else begin
      m_mode = e_mode;
      if (ld) m_epc = bus.pc_cur;
      if (bump && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    bus.pc_cur = got_next;
    clear_req();
  endtask

  task automatic jump_to(input logic [7:0] tgt);
    bus.jmp = 1'b1;
    bus.jmp_target = tgt;
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_mode   = M_BOOT;
    m_epc    = 8'h00;
    m_cnt    = 0;
    rst      = 1'b1;
    bus.pc_cur     = 8'h00;
    bus.br_target  = 8'h00;
    bus.jmp_target = 8'h00;
    clear_req();
    @(posedge clk);
    #1;

    // Reset, then a sequential run from the reset vector.
    repeat (5) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("seq_pc", {24'd0, bus.pc_next}, 2 * (i + 1));
      check_eq("seq_flush", {31'd0, bus.flush}, 32'd0);
      tick();
    end

    // Taken branch, then a jump during FLUSH that must be ignored.
    bus.br_taken = 1'b1;
    bus.br_target = 8'h40;
    #1;
    check_eq("br_pc", {24'd0, bus.pc_next}, 32'h40);
    check_eq("br_flush", {31'd0, bus.flush}, 32'd1);
    tick();
    bus.jmp = 1'b1;
    bus.jmp_target = 8'h80;
    #1;
    check_eq("squash_pc", {24'd0, bus.pc_next}, 32'h42);
    check_eq("squash_flush", {31'd0, bus.flush}, 32'd1);
    tick();
    check_eq("br_cnt", {24'd0, bus.redirect_cnt}, 32'd1);

    // Stall for three cycles at 0x10.
    jump_to(8'h0E);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1;
      #1;
      check_eq("stall_pc", {24'd0, bus.pc_next}, 32'h10);
      tick();
    end
    #1;
    check_eq("unstall_pc", {24'd0, bus.pc_next}, 32'h12);
    tick();

    // Sequential increment wraps from 0xFE to 0x00.
    jump_to(8'hFC);
    #1;
    check_eq("wrap_pc", {24'd0, bus.pc_next}, 32'h00);
    tick();

    // Halt at 0x20, hold for ten cycles, then resume.
    jump_to(8'h1E);
    bus.halt_req = 1'b1;
    #1;
    check_eq("halt_pc", {24'd0, bus.pc_next}, 32'h20);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("halt_hold", {24'd0, bus.pc_next}, 32'h20);
      check_eq("halted", {31'd0, bus.halted}, 32'd1);
      tick();
    end
    bus.resume = 1'b1;
    tick();
    #1;
    check_eq("resume_pc", {24'd0, bus.pc_next}, 32'h22);
    check_eq("resume_halted", {31'd0, bus.halted}, 32'd0);
    tick();

    // Halt again, then take an exception while halted.
    jump_to(8'h1E);
    bus.halt_req = 1'b1;
    tick();
    bus.exc = 1'b1;
    #1;
    check_eq("hexc_pc", {24'd0, bus.pc_next}, 32'hF0);
    tick();
    check_eq("hexc_epc", {24'd0, bus.epc}, 32'h20);
    check_eq("hexc_state", {30'd0, bus.state}, 32'd2);
    tick();

    // Exception wins over branch, jump and stall.
    jump_to(8'h2E);
    cnt0 = m_cnt;
    bus.exc = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 8'h55;
    bus.jmp = 1'b1;
    bus.jmp_target = 8'h66;
    bus.stall = 1'b1;
    #1;
    check_eq("prio_pc", {24'd0, bus.pc_next}, 32'hF0);
    tick();
    check_eq("prio_epc", {24'd0, bus.epc}, 32'h30);
    check_eq("prio_cnt", {24'd0, bus.redirect_cnt}, cnt0 + 1);

    // Reset asserted during FLUSH.
    rst = 1'b1;
    #1;
    check_eq("rst_pc", {24'd0, bus.pc_next}, 32'h00);
    tick();
    check_eq("rst_state", {30'd0, bus.state}, 32'd0);
    check_eq("rst_epc", {24'd0, bus.epc}, 32'h00);
    check_eq("rst_cnt", {24'd0, bus.redirect_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // 300 taken jumps, with the jump held through FLUSH, saturate the counter.
    for (int i = 0; i < 600; i++) begin
      bus.jmp = 1'b1;
      bus.jmp_target = 8'($urandom_range(0, 127) * 2);
      tick();
    end
    check_eq("sat_cnt", {24'd0, bus.redirect_cnt}, 32'd255);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      bus.exc       = ($urandom_range(0, 15) == 0);
      bus.br_taken  = ($urandom_range(0, 7) == 0);
      bus.jmp       = ($urandom_range(0, 7) == 0);
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.halt_req  = ($urandom_range(0, 15) == 0);
      bus.resume    = ($urandom_range(0, 3) == 0);
      bus.br_target  = 8'($urandom_range(0, 255));
      bus.jmp_target = 8'($urandom_range(0, 255));
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 8-bit program counter register. It computes the value driven into the PC register's `pc_input` each cycle from the PC register's current `pc_output` and from redirect, stall, halt and exception requests. It owns the front-end flush signal, the halt state, the exception PC capture and a redirect counter. It sits between the hazard/branch/decode logic and the `pc` register.

## Interface
- `PC_W`, 8: PC width in bits.
- `INC`, 2: sequential increment (bytes per instruction).
- `RESET_VEC`, 8'h00: PC value presented during and right after reset.
- `EXC_VEC`, 8'hF0: exception handler address.

- `clk`  in  1  rising-edge clock shared with `pc`.
- `rst`  in  1  reset, synchronous and active-high.
- `pc_cur`  in  PC_W  current PC; connects to `pc.pc_output`.
- `stall`  in  1  hazard hold request.
- `br_taken`  in  1  branch resolved taken.
- `br_target`  in  PC_W  branch destination.
- `jmp`  in  1  unconditional jump.
- `jmp_target`  in  PC_W  jump destination.
- `halt_req`  in  1  halt instruction decoded.
- `resume`  in  1  leave HALT.
- `exc`  in  1  exception (illegal opcode or overflow).
- `pc_next`  out  PC_W  next PC; connects to `pc.pc_input`. Combinational.
- `flush`  out  1  kill the fetch/decode instruction. Combinational.
- `halted`  out  1  high while in HALT. Decoded from the state register.
- `epc`  out  PC_W  PC captured at the last exception. Registered.
- `redirect_cnt`  out  8  count of taken redirects. Registered, saturating.
- `state`  out  2  BOOT=0, RUN=1, FLUSH=2, HALT=3.

## Operation
- All registers (state, epc, redirect_cnt) update only on the rising edge of `clk`.
- While `rst`=1:
  - on every edge: state<=BOOT, epc<=0, redirect_cnt<=0;
  - combinationally: `pc_next`=RESET_VEC, `flush`=1, `halted`=0.
- `pc_cur+INC` is computed modulo 2^PC_W: 8'hFE+2 = 8'h00. No carry out.
- BOOT:
  - `pc_next`=RESET_VEC, `flush`=1;
  - all requests ignored, including `exc`;
  - next state RUN.
- RUN, evaluated in strict priority order (first match wins):
  1. `exc`: `pc_next`=EXC_VEC, `flush`=1, epc<=`pc_cur`, count++, next state FLUSH.
  2. `br_taken`: `pc_next`=`br_target`, `flush`=1, count++, next state FLUSH.
  3. `jmp`: `pc_next`=`jmp_target`, `flush`=1, count++, next state FLUSH.
  4. `stall`: `pc_next`=`pc_cur`, stay in RUN. `stall` beats `halt_req`, because the halt instruction is not yet valid.
  5. `halt_req`: `pc_next`=`pc_cur`, next state HALT.
  6. Otherwise: `pc_next`=`pc_cur+INC`.
- FLUSH (exactly one bubble cycle; the instruction in this slot is wrong-path):
  - `flush`=1;
  - `br_taken`, `jmp`, `halt_req` and `stall` are ignored;
  - `exc` is honoured exactly as in RUN: new vector, epc update, count++, stay in FLUSH;
  - otherwise `pc_next`=`pc_cur+INC`, next state RUN.
- HALT:
  - `halted`=1, `flush`=0, `pc_next`=`pc_cur`;
  - `exc` is honoured as in RUN and exits to FLUSH;
  - `resume` (with no `exc`) keeps `pc_next`=`pc_cur` that cycle and sets next state RUN;
  - all other requests are ignored.
- In every state where `flush` is not explicitly set, `flush`=0.
- redirect_cnt stops at 255 and does not wrap.

## Timing
- Zero-cycle combinational path from `pc_cur`, requests and state to `pc_next` and `flush`.
- The PC register captures `pc_next` at the next edge, so `pc_cur` reflects a decision one cycle later.
- Branch penalty is 2 flushed slots: the redirect cycle plus the FLUSH cycle.
- First post-reset fetch: `rst` falls before edge N. Edge N leaves BOOT and loads RESET_VEC into `pc`. The first RUN cycle follows with `pc_cur`=RESET_VEC.
- Reset mid-operation (any state, including FLUSH or HALT) takes effect at the next edge. `pc_next`=RESET_VEC in the same cycle `rst` is high.
- HALT entry: `halted` rises one cycle after the `halt_req` cycle. After `resume`, `halted` falls at the next edge.

## Test plan
- Reset then sequential run: hold `rst`=1 for 5 cycles, then release with all requests 0 → `pc_cur` = 0x00, 0x02, 0x04, 0x06; `flush`=0 in RUN; redirect_cnt=0.
- Branch and squash:
  - at `pc_cur`=0x06 assert `br_taken` with `br_target`=0x40 → `pc_next`=0x40 and `flush`=1 that cycle;
  - next cycle (FLUSH) assert `jmp` with `jmp_target`=0x80 → ignored, `pc_next`=0x42, `flush`=1;
  - redirect_cnt=1.
- Stall and wrap:
  - `stall`=1 for 3 cycles at `pc_cur`=0x10 → `pc_next`=0x10 three times, then 0x12;
  - at `pc_cur`=0xFE with no requests → `pc_next`=0x00.
- Halt/resume/exception:
  - `halt_req` at 0x20 → `halted`=1 next cycle, PC holds 0x20 for 10 cycles;
  - `resume` → `pc_cur` 0x20 then 0x22;
  - repeat the halt, then assert `exc` in HALT → `pc_next`=0xF0, epc=0x20, state FLUSH.
- Priority: `exc`+`br_taken`+`jmp`+`stall` together in RUN at 0x30 → `pc_next`=0xF0, epc=0x30, redirect_cnt increments by 1.
- Reset mid-operation and counter saturation:
  - assert `rst` during FLUSH → BOOT next edge, epc=0, redirect_cnt=0, `pc_next`=0x00;
  - 300 consecutive jumps → redirect_cnt holds at 255.
